spi_mem_target: RTL and testbench

- Synthesizable SPI mode-0 target that models the external serial memory seen by the SPI cache master.
- Serves the master's init writes (WREN, WRSR) and the read/write traffic used after init.
- Oversamples the SPI pins with the system clock and backs a byte array of MEM_DEPTH entries.
- Used as the memory-side endpoint in integration and FPGA loopback builds.

---
 rtl/spi_mem_pkg.sv | 15 +
 rtl/spi_mem_target_spi_pin_sync.sv | 35 +++
 rtl/spi_mem_target.sv | 160 ++++++++++++++++
 tb/tb_spi_mem_target.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: opcodes, FSM states and status bit positions for the SPI memory target
package spi_mem_pkg;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam int ST_WIP = 0;
    localparam int ST_WEL = 1;
    localparam int ST_QE  = 6;
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_RD_DATA, S_WR_DATA, S_RD_STAT, S_WR_STAT, S_IGNORE
    } state_t;
endpackage

// File: rtl/spi_mem_target_spi_pin_sync.sv
// spi_pin_sync: brings the SPI pins into the clk domain and derives sclk/cs edge pulses
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_active_o,
    output logic cs_start_o,
    output logic cs_end_o,
    output logic mosi_o
);
    logic [2:0] sclk_q;
    logic [2:0] cs_n_q;
    logic [1:0] mosi_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= 3'b000;
            cs_n_q <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_i};
            cs_n_q <= {cs_n_q[1:0], cs_n_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end
    assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];
    assign cs_active_o = ~cs_n_q[1];
    assign cs_start_o  = ~cs_n_q[1] & cs_n_q[2];
    assign cs_end_o    = cs_n_q[1] & ~cs_n_q[2];
    assign mosi_o      = mosi_q[1];
endmodule

// File: rtl/spi_mem_target.sv
// spi_mem_target: SPI mode-0 serial memory model with status register and write-enable latch
module spi_mem_target
    import spi_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sclk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic spi_miso_oe,
    output logic init_done,
    output logic wel,
    output logic proto_err
);
    localparam int AW = $clog2(MEM_DEPTH);
    logic sclk_rise, sclk_fall, cs_active, cs_start, cs_end, mosi_s;
    state_t state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d, op_q, op_d, rx_nxt, status;
    logic [AW-1:0] addr_q, addr_d, addr_nxt, addr_inc;
    logic wel_q, wel_d, qe_q, qe_d, miso_q, miso_d, perr_q, perr_d, mem_we;
    logic [7:0] mem_q [MEM_DEPTH];

    spi_pin_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .sclk_i      (spi_sclk),
        .cs_n_i      (spi_cs_n),
        .mosi_i      (spi_mosi),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .cs_active_o (cs_active),
        .cs_start_o  (cs_start),
        .cs_end_o    (cs_end),
        .mosi_o      (mosi_s)
    );

    always_comb begin
        status = 8'h00;
        status[ST_WIP] = 1'b0;
        status[ST_WEL] = wel_q;
        status[ST_QE] = qe_q;
    end

    assign rx_nxt = {rx_q, mosi_s};
    assign addr_nxt = AW'({addr_q, mosi_s});
    assign addr_inc = addr_q + AW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rx_d = rx_q;
        tx_d = tx_q;
        addr_d = addr_q;
        op_d = op_q;
        wel_d = wel_q;
        qe_d = qe_q;
        miso_d = miso_q;
        perr_d = 1'b0;
        mem_we = 1'b0;
        // CS rise wins over everything and settles the write-enable latch for the finished command
        if (cs_end) begin
            state_d = S_IDLE;
            cnt_d = 5'd0;
            miso_d = 1'b0;
            wel_d = (op_q == OP_WREN) ? 1'b1 : (op_q inside {OP_WRDI, OP_WRITE, OP_WRSR}) ? 1'b0 : wel_q;
        end else if (cs_start) begin
            state_d = S_CMD;
            cnt_d = 5'd0;
            op_d = 8'h00;
        end else begin
            case (state_q)
                S_CMD: if (sclk_rise) begin
                    rx_d = rx_nxt[6:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d = 5'd0;
                        op_d = rx_nxt;
                        tx_d = status;
                        state_d = (rx_nxt == OP_RDSR) ? S_RD_STAT :
                                  (rx_nxt == OP_WRSR) ? S_WR_STAT :
                                  (rx_nxt == OP_READ || rx_nxt == OP_WRITE) ? S_ADDR : S_IGNORE;
                        perr_d = !(rx_nxt inside {OP_WREN, OP_WRDI, OP_RDSR, OP_WRSR, OP_READ, OP_WRITE});
                    end
                end
                S_ADDR: if (sclk_rise) begin
                    addr_d = addr_nxt;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        cnt_d = 5'd0;
                        tx_d = mem_q[addr_nxt];
                        state_d = (op_q == OP_READ) ? S_RD_DATA : S_WR_DATA;
                    end
                end
                S_RD_DATA, S_RD_STAT: if (sclk_fall) begin
                    miso_d = tx_q[7];
                    cnt_d = cnt_q + 5'd1;
                    tx_d = {tx_q[6:0], 1'b0};
                    if (cnt_q == 5'd7) begin
                        cnt_d = 5'd0;
                        addr_d = (state_q == S_RD_DATA) ? addr_inc : addr_q;
                        tx_d = (state_q == S_RD_DATA) ? mem_q[addr_inc] : status;
                    end
                end
                S_WR_DATA, S_WR_STAT: if (sclk_rise) begin
                    rx_d = rx_nxt[6:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d = 5'd0;
                        mem_we = wel_q && state_q == S_WR_DATA;
                        addr_d = mem_we ? addr_inc : addr_q;
                        qe_d = (wel_q && state_q == S_WR_STAT) ? rx_nxt[ST_QE] : qe_q;
                        state_d = (state_q == S_WR_STAT) ? S_IGNORE : S_WR_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q <= 5'd0;
            rx_q <= 7'd0;
            tx_q <= 8'h00;
            addr_q <= '0;
            op_q <= 8'h00;
            wel_q <= 1'b0;
            qe_q <= 1'b0;
            miso_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rx_q <= rx_d;
            tx_q <= tx_d;
            addr_q <= addr_d;
            op_q <= op_d;
            wel_q <= wel_d;
            qe_q <= qe_d;
            miso_q <= miso_d;
            perr_q <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem_q[addr_q] <= rx_nxt;
    end

    assign spi_miso_oe = cs_active && (state_q == S_RD_DATA || state_q == S_RD_STAT);
    assign spi_miso = spi_miso_oe & miso_q;
    assign init_done = qe_q;
    assign wel = wel_q;
    assign proto_err = perr_q;
endmodule

// File: tb/tb_spi_mem_target.sv
// tb_spi_mem_target: directed SPI transactions with a queue-based scoreboard and monitor
module tb_spi_mem_target;
    import spi_mem_pkg::*;
    localparam int HALF = 50;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso, oe, init_done, wel, proto_err;
    int checks = 0;
    int errors = 0;
    int perr_cnt = 0;
    typedef struct {
        string name;
        logic [7:0] val;
    } exp_t;
    exp_t exp_q[$];
    event obs_ev;
    logic [7:0] obs_val;

    always #5 clk = ~clk;

    spi_mem_target #(.MEM_DEPTH(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (sclk),
        .spi_cs_n    (cs_n),
        .spi_mosi    (mosi),
        .spi_miso    (miso),
        .spi_miso_oe (oe),
        .init_done   (init_done),
        .wel         (wel),
        .proto_err   (proto_err)
    );

    always @(posedge clk) if (proto_err) perr_cnt <= perr_cnt + 1;

    initial begin
        exp_t e;
        forever begin
            @(obs_ev);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_obs: got %h, no expected value queued", obs_val);
            end else begin
                e = exp_q.pop_front();
                if (obs_val !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, obs_val, e.val);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic expect_v(input string n, input logic [7:0] v);
        exp_q.push_back('{n, v});
    endtask

    task automatic observe(input logic [7:0] v);
        obs_val = v;
        ->obs_ev;
        @(negedge clk);
    endtask

    task automatic chk(input string n, input logic [7:0] exp, input logic [7:0] act);
        expect_v(n, exp);
        observe(act);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx, output logic [7:0] oeb);
        rx = 8'h00;
        oeb = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[i];
            #HALF;
            rx[i] = miso;
            oeb[i] = oe;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
    endtask

    task automatic cs_lo();
        @(negedge clk);
        cs_n = 1'b0;
        #(2 * HALF);
    endtask

    task automatic cs_hi();
        #(2 * HALF);
        cs_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] r, o;
        xfer(b, 8, r, o);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
    endtask

    task automatic simple(input logic [7:0] op);
        cs_lo();
        send(op);
        cs_hi();
    endtask

    task automatic write_bytes(input logic [23:0] a, input logic [31:0] d, input int n);
        cs_lo();
        send(OP_WRITE);
        send_addr(a);
        for (int i = 0; i < n; i++) send(d[31 - 8 * i -: 8]);
        cs_hi();
    endtask

    task automatic read_chk(input string nm, input logic [23:0] a, input logic [31:0] d, input int n);
        logic [7:0] r, o;
        cs_lo();
        send(OP_READ);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            expect_v(nm, d[31 - 8 * i -: 8]);
            xfer(8'h00, 8, r, o);
            observe(r);
        end
        cs_hi();
    endtask

    task automatic rdsr_chk(input string nm, input logic [7:0] exp);
        logic [7:0] r, o;
        cs_lo();
        xfer(OP_RDSR, 8, r, o);
        chk({nm, "_cmd_oe"}, 8'h00, o);
        for (int i = 0; i < 2; i++) begin
            xfer(8'h00, 8, r, o);
            chk(nm, exp, r);
            chk({nm, "_oe"}, 8'hFF, o);
        end
        cs_hi();
        chk({nm, "_oe_after"}, 8'h00, {7'd0, oe});
    endtask

    initial begin
        logic [7:0] r, o, s_oe, s_st;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_init_done", 8'h00, {7'd0, init_done});
        chk("rst_wel", 8'h00, {7'd0, wel});
        chk("rst_oe", 8'h00, {7'd0, oe});
        chk("rst_miso", 8'h00, {7'd0, miso});
        rdsr_chk("rdsr_reset", 8'h00);
        chk("rdsr_init_done", 8'h00, {7'd0, init_done});

        cs_lo(); send(OP_WRSR); send(8'h40); cs_hi();
        chk("wrsr_nowren_qe", 8'h00, {7'd0, init_done});
        simple(OP_WREN);
        chk("wren_wel", 8'h01, {7'd0, wel});
        simple(OP_WRDI);
        chk("wrdi_wel", 8'h00, {7'd0, wel});
        simple(OP_WREN);
        cs_lo(); send(OP_WRSR); send(8'hFF & 8'h40); cs_hi();
        chk("wrsr_qe", 8'h01, {7'd0, init_done});
        chk("wrsr_wel", 8'h00, {7'd0, wel});
        rdsr_chk("rdsr_init", 8'h40);

        simple(OP_WREN);
        write_bytes(24'h0000FE, 32'hA55AC300, 3);
        chk("write_wel", 8'h00, {7'd0, wel});
        read_chk("read_wrap", 24'h0000FE, 32'hA55AC300, 3);
        read_chk("read_hi_addr", 24'hABCD00, 32'hC3000000, 1);

        simple(OP_WREN);
        write_bytes(24'h000020, 32'h003C0000, 2);
        simple(OP_WREN);
        write_bytes(24'h000010, 32'h99000000, 1);
        write_bytes(24'h000010, 32'h77000000, 1);
        chk("nowren_wel", 8'h00, {7'd0, wel});
        read_chk("nowren_read", 24'h000010, 32'h99000000, 1);

        simple(OP_WREN);
        cs_lo(); send(OP_WRITE); send_addr(24'h000020); send(8'h11); xfer(8'hFF, 5, r, o); cs_hi();
        chk("partial_wel", 8'h00, {7'd0, wel});
        read_chk("partial_read", 24'h000020, 32'h113C0000, 2);

        simple(OP_WREN);
        read_chk("read_keep", 24'h000021, 32'h3C000000, 1);
        chk("read_keep_wel", 8'h01, {7'd0, wel});
        simple(OP_WRDI);

        cs_lo();
        xfer(8'h9F, 8, r, o);
        xfer(8'h00, 8, r, o);
        chk("ignore_oe", 8'h00, o);
        cs_hi();
        chk("perr_cnt", 8'h01, perr_cnt[7:0]);
        rdsr_chk("rdsr_after_err", 8'h40);

        cs_lo(); send(OP_READ); send_addr(24'h000020); xfer(8'h00, 3, r, o);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        s_oe = {7'd0, oe};
        s_st = 8'(dut.state_q);
        chk("rst_mid_oe", 8'h00, s_oe);
        chk("rst_mid_state", 8'(S_IDLE), s_st);
        rst = 1'b0;
        cs_n = 1'b1;
        #(4 * HALF);
        chk("rst_mid_qe", 8'h00, {7'd0, init_done});
        chk("rst_mid_wel", 8'h00, {7'd0, wel});

        #(10 * HALF);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
